// File: rtl/matrix_mult_nxn.sv
// Sequential N x N integer matrix multiplier, C = A x B.
// Operands are captured when a start is accepted. Each RUN cycle issues one
// C element: N shared multipliers form A[i][k]*B[k][j] for k=0..N-1 into a
// product register (stage 1), and an adder tree sums the registered products
// into C[idx_d] on the next edge (stage 2). One element completes per cycle.

module matrix_mult_nxn #(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    localparam int OW    = 2*DW + $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*N*DW-1:0]   a_flat,
    input  logic [N*N*DW-1:0]   b_flat,
    output logic [N*N*OW-1:0]   c_flat,
    output logic                busy,
    output logic                done
);

    localparam int RW = $clog2(N);
    localparam int IW = $clog2(N*N);
    localparam int PW = 2*DW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              busy_next, done_next;
    logic              capture, issue, last;

    logic [N*N*DW-1:0] a_q, b_q;
    logic [RW-1:0]     row, col;

    logic [DW-1:0]     a_sel [N];
    logic [DW-1:0]     b_sel [N];
    logic [PW-1:0]     a_ext [N];
    logic [PW-1:0]     b_ext [N];
    logic [PW-1:0]     prod  [N];

    logic [PW-1:0]     prod_q [N];
    logic              valid_q;
    logic [IW-1:0]     idx_d;
    logic [OW-1:0]     sum;

    assign last = (row == RW'(N-1)) && (col == RW'(N-1));

    // State register and the registered status outputs.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so that all
        // registers update together from values sampled before the edge.
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state logic and control strobes for the datapath.
    always_comb begin
        // NOTE: each output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_next = state;
        busy_next  = busy;
        done_next  = 1'b0;
        capture    = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    busy_next  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The last element lands in c_flat on this edge.
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Row i of A and column j of B feed the N multipliers; operands are
    // widened (zero or sign) to 2*DW so one unsigned multiply serves both
    // modes, its low 2*DW bits being the exact product.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            a_sel[k] = a_q[(int'(row)*N + k)*DW +: DW];
            b_sel[k] = b_q[(k*N + int'(col))*DW +: DW];
            a_ext[k] = {{DW{(SIGNED != 0) && a_sel[k][DW-1]}}, a_sel[k]};
            b_ext[k] = {{DW{(SIGNED != 0) && b_sel[k][DW-1]}}, b_sel[k]};
            prod[k]  = a_ext[k] * b_ext[k];
        end
    end

    // Adder tree over the registered products, each extended to OW first.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + {{(OW-PW){(SIGNED != 0) && prod_q[k][PW-1]}}, prod_q[k]};
        end
    end

    // Operand capture, element sequencing, stage-1 product register and
    // stage-2 result write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and product arrays are cleared as well, so an
            // aborted operation leaves no stale matrix data behind.
            a_q     <= '0;
            b_q     <= '0;
            row     <= '0;
            col     <= '0;
            valid_q <= 1'b0;
            idx_d   <= '0;
            c_flat  <= '0;
            for (int k = 0; k < N; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            if (capture) begin
                a_q <= a_flat;
                b_q <= b_flat;
                row <= '0;
                col <= '0;
            end

            valid_q <= issue;
            if (issue) begin
                for (int k = 0; k < N; k++) begin
                    prod_q[k] <= prod[k];
                end
                idx_d <= IW'(int'(row)*N + int'(col));
                if (last) begin
                    row <= '0;
                    col <= '0;
                end else if (col == RW'(N-1)) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + RW'(1);
                end
            end

            // Stage 2 is independent of the FSM state: it drains whatever
            // stage 1 holds, which is how FLUSH completes the final element.
            if (valid_q) begin
                c_flat[int'(idx_d)*OW +: OW] <= sum;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_nxn.sv
// Directed bench for matrix_mult_nxn: a 2x2 unsigned, a 2x2 signed and a
// 4x4 unsigned instance, driven from a vector table plus hand sequences for
// reset abort, ignored start, operand isolation and back-to-back starts.

module tb_matrix_mult_nxn;

    logic         clk = 1'b0;
    logic         rst;

    // Shared 2x2 stimulus; sel routes start and outputs to one instance.
    logic         start2;
    logic         sel;
    logic [31:0]  a2, b2;
    logic         start_u, start_s;
    logic [67:0]  c_u, c_s;
    logic         busy_u, busy_s, done_u, done_s;

    logic         start4;
    logic [127:0] a4, b4;
    logic [287:0] c4;
    logic         busy4, done4;

    logic         cur_busy, cur_done;
    logic [67:0]  cur_c;

    int n_checks = 0;
    int n_errors = 0;

    assign start_u  = start2 && !sel;
    assign start_s  = start2 && sel;
    assign cur_busy = sel ? busy_s : busy_u;
    assign cur_done = sel ? done_s : done_u;
    assign cur_c    = sel ? c_s    : c_u;

    matrix_mult_nxn #(.N(2), .DW(8), .SIGNED(0)) u_u2 (
        .clk(clk), .rst(rst), .start(start_u), .a_flat(a2), .b_flat(b2),
        .c_flat(c_u), .busy(busy_u), .done(done_u)
    );

    matrix_mult_nxn #(.N(2), .DW(8), .SIGNED(1)) u_s2 (
        .clk(clk), .rst(rst), .start(start_s), .a_flat(a2), .b_flat(b2),
        .c_flat(c_s), .busy(busy_s), .done(done_s)
    );

    matrix_mult_nxn #(.N(4), .DW(8), .SIGNED(0)) u_u4 (
        .clk(clk), .rst(rst), .start(start4), .a_flat(a4), .b_flat(b4),
        .c_flat(c4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             sgn;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][16:0] c;
    } vec_t;

    localparam int NV = 5;
    vec_t  vecs  [NV];
    string names [NV];

    function automatic vec_t mk(input int s,
                                input int a0, input int a1, input int a2_, input int a3,
                                input int b0, input int b1, input int b2_, input int b3,
                                input int c0, input int c1, input int c2, input int c3);
        vec_t v;
        v.sgn  = (s != 0);
        v.a[0] = 8'(a0);  v.a[1] = 8'(a1);  v.a[2] = 8'(a2_); v.a[3] = 8'(a3);
        v.b[0] = 8'(b0);  v.b[1] = 8'(b1);  v.b[2] = 8'(b2_); v.b[3] = 8'(b3);
        v.c[0] = 17'(c0); v.c[1] = 17'(c1); v.c[2] = 17'(c2);  v.c[3] = 17'(c3);
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Called at a negedge: present operands and start, let the edge accept
    // them, then scramble the inputs to prove they were captured.
    task automatic launch(input vec_t v);
        sel    = v.sgn;
        a2     = v.a;
        b2     = v.b;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        a2     = $urandom();
        b2     = $urandom();
    endtask

    // Samples at each negedge after the accepting edge (k=0 first) until done;
    // done is required at k=5 with busy high before it and low with it.
    task automatic wait_done(input vec_t v, input string nm,
                             input bit chk_prev, input vec_t prev);
        int  k;
        bit  seen;
        bit  busy_ok;
        k       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        if (chk_prev) begin
            for (int e = 0; e < 4; e++) begin
                check({nm, " prev_hold"}, 64'(cur_c[e*17 +: 17]), 64'(prev.c[e]));
            end
        end
        while (!seen && k < 20) begin
            if (cur_done) begin
                seen = 1'b1;
            end else begin
                if (cur_busy !== 1'b1) busy_ok = 1'b0;
                k++;
                @(negedge clk);
            end
        end
        check({nm, " done_latency"}, 64'(seen ? k : -1), 64'(5));
        check({nm, " busy_during_run"}, 64'(busy_ok), 64'(1));
        check({nm, " busy_low_at_done"}, 64'(cur_busy), 64'(0));
        for (int e = 0; e < 4; e++) begin
            check({nm, " c_elem"}, 64'(cur_c[e*17 +: 17]), 64'(v.c[e]));
        end
    endtask

    // One cycle after done: the pulse has ended and the result holds.
    task automatic check_after(input vec_t v, input string nm);
        @(negedge clk);
        check({nm, " done_single_pulse"}, 64'(cur_done), 64'(0));
        for (int e = 0; e < 4; e++) begin
            check({nm, " c_hold"}, 64'(cur_c[e*17 +: 17]), 64'(v.c[e]));
        end
    endtask

    initial begin
        int  first_done;
        int  n_done;
        bit  any_done;
        logic [287:0] c4_snap;

        vecs[0] = mk(0, 1, 2, 3, 4,  5, 6, 7, 8,  19, 22, 43, 50);
        names[0] = "u_basic";
        vecs[1] = mk(0, 255, 255, 255, 255,  255, 255, 255, 255,
                     130050, 130050, 130050, 130050);
        names[1] = "u_max";
        vecs[2] = mk(1, -1, 2, 3, -4,  5, 6, 7, 8,  9, 10, -13, -14);
        names[2] = "s_basic";
        vecs[3] = mk(1, -128, -128, -128, -128,  -128, -128, -128, -128,
                     32768, 32768, 32768, 32768);
        names[3] = "s_min";
        vecs[4] = mk(1, 127, -128, 1, 0,  -128, 127, 2, -1,
                     -16512, 16257, -128, 127);
        names[4] = "s_mixed";

        // Reset asserted together with start: reset wins.
        sel    = 1'b0;
        rst    = 1'b1;
        start2 = 1'b1;
        start4 = 1'b1;
        a2     = vecs[0].a;
        b2     = vecs[0].b;
        a4     = '0;
        b4     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_over_start busy", 64'(busy_u), 64'(0));
        rst    = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        @(negedge clk);
        check("reset busy_done", 64'({busy_u, busy_s, busy4, done_u, done_s, done4}), 64'(0));
        check("reset c_u", 64'(c_u[63:0] | 64'(c_u[67:64])), 64'(0));
        check("reset c_s", 64'(c_s[63:0] | 64'(c_s[67:64])), 64'(0));
        check("reset c4", 64'(|c4), 64'(0));

        // Table-driven 2x2 vectors.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            launch(vecs[i]);
            wait_done(vecs[i], names[i], 1'b0, vecs[i]);
            check_after(vecs[i], names[i]);
        end

        // 4x4: identity times 1..16, operands scrambled and start re-pulsed
        // while running; exactly one done, 17 cycles after the start edge.
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a4[(r*4+c)*8 +: 8] = (r == c) ? 8'd1 : 8'd0;
                b4[(r*4+c)*8 +: 8] = 8'(r*4 + c + 1);
            end
        end
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        b4 = {$urandom(), $urandom(), $urandom(), $urandom()};
        first_done = -1;
        n_done     = 0;
        c4_snap    = '0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done4) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k;
                    c4_snap    = c4;
                end
            end
            start4 = (k == 3);
        end
        start4 = 1'b0;
        check("n4 done_latency", 64'(first_done), 64'(17));
        check("n4 done_count", 64'(n_done), 64'(1));
        for (int e = 0; e < 16; e++) begin
            check("n4 c_at_done", 64'(c4_snap[e*18 +: 18]), 64'(e + 1));
        end
        check("n4 c_hold_elem15", 64'(c4[15*18 +: 18]), 64'(16));

        // Reset in the third RUN cycle aborts with everything cleared.
        @(negedge clk);
        launch(vecs[1]);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy_u), 64'(0));
        check("abort done", 64'(done_u), 64'(0));
        check("abort c_u", 64'(c_u[63:0] | 64'(c_u[67:64])), 64'(0));
        any_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_u || busy_u) any_done = 1'b1;
        end
        check("abort no_done_after", 64'(any_done), 64'(0));
        launch(vecs[0]);
        wait_done(vecs[0], "after_abort", 1'b0, vecs[0]);

        // Back-to-back: new start in the done cycle of the previous run.
        launch(vecs[1]);
        wait_done(vecs[1], "b2b_second", 1'b1, vecs[0]);
        check_after(vecs[1], "b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
